// File: rtl/fpu_issue.sv
// fpu_issue: FP issue/writeback sequencer sitting in front of the FPU wrapper.
// Owns the 32x32 FP register file, issues one decoded op at a time to the FPU,
// holds the FPU operands stable until the FPU answers, writes the result back,
// and aborts the op with a one-cycle error pulse if the FPU never answers.
module fpu_issue #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [3:0]  dec_op,
    input  logic [4:0]  dec_rd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        ld_we,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic [4:0]  rf_raddr,
    output logic [31:0] rf_rdata,
    output logic [3:0]  fpu_ctl,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    output logic        fpu_en,
    input  logic        fpu_ready,
    input  logic [31:0] fpu_y,
    output logic        done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Last counter value still allowed to wait; reaching it without a ready aborts.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic          accept_s;
    logic          wb_s;
    logic          abort_s;

    logic [31:0]   rf_r [32];
    logic [4:0]    rd_r;
    logic [CW-1:0] cnt_r;
    logic [3:0]    fpu_ctl_r;
    logic [31:0]   fpu_x1_r;
    logic [31:0]   fpu_x2_r;
    logic          fpu_en_r;
    logic          done_r;
    logic          timeout_err_r;

    // Next-state decode plus the accept / writeback / abort strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        wb_s        = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dec_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_ready) begin
                    wb_s        = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == TO_LAST) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, FPU handshake outputs, status pulses and wait counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fpu_ctl_r     <= 4'd0;
            fpu_x1_r      <= 32'd0;
            fpu_x2_r      <= 32'd0;
            rd_r          <= 5'd0;
            cnt_r         <= '0;
            fpu_en_r      <= 1'b0;
            done_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            // Operands reflect the register file before this edge: no load forwarding.
            if (accept_s) begin
                fpu_ctl_r <= dec_op;
                fpu_x1_r  <= rf_r[dec_rs1];
                fpu_x2_r  <= rf_r[dec_rs2];
                rd_r      <= dec_rd;
            end else begin
                fpu_ctl_r <= fpu_ctl_r;
                fpu_x1_r  <= fpu_x1_r;
                fpu_x2_r  <= fpu_x2_r;
                rd_r      <= rd_r;
            end
            if (state_r == ST_ISSUE) begin
                cnt_r <= '0;
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            // fpu_en is high exactly in the ISSUE cycle that follows an accept.
            fpu_en_r      <= accept_s;
            done_r        <= wb_s;
            timeout_err_r <= abort_s;
        end
    end

    // Register file: load port first, FPU writeback last so it wins on the same address.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else begin
            if (ld_we) begin
                rf_r[ld_addr] <= ld_data;
            end
            if (wb_s) begin
                rf_r[rd_r] <= fpu_y;
            end
        end
    end

    assign dec_ready   = (state_r == ST_IDLE);
    assign rf_rdata    = rf_r[rf_raddr];
    assign fpu_ctl     = fpu_ctl_r;
    assign fpu_x1      = fpu_x1_r;
    assign fpu_x2      = fpu_x2_r;
    assign fpu_en      = fpu_en_r;
    assign done        = done_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: table of FP ops run through a behavioural FPU model,
// expected writebacks kept in a scoreboard queue, plus hand-written reset and
// spurious-ready sequences.
module tb_fpu_issue;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rstn;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_op;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        ld_we;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [3:0]  fpu_ctl;
    logic [31:0] fpu_x1;
    logic [31:0] fpu_x2;
    logic        fpu_en;
    logic        fpu_ready;
    logic [31:0] fpu_y;
    logic        done;
    logic        timeout_err;

    logic        model_ready;
    logic        spur_ready;
    int          stage;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          hold;
        bit          to;
        bit          col;
        logic [4:0]  la;
        logic [31:0] ld;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] y;
    } sb_t;

    sb_t         sb_q [$];
    logic [31:0] shadow [32];
    vec_t        vecs [7];
    int          n_vec;
    int          n_err;

    assign fpu_ready = model_ready | spur_ready;

    fpu_issue #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
        .clk(clk), .rstn(rstn),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .fpu_ctl(fpu_ctl), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_en(fpu_en),
        .fpu_ready(fpu_ready), .fpu_y(fpu_y),
        .done(done), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference FP result; 1.0 + 2.0 gives 3.0, other pairs use an easily checked mix.
    function automatic logic [31:0] fmodel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 4'd2 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a + b + {28'd0, op};
    endfunction

    // FPU model: ready pulses in the cycle three cycles after fpu_en; op 7 is never answered.
    initial begin
        stage = 0;
        model_ready = 1'b0;
        fpu_y = 32'd0;
    end
    always @(posedge clk) begin
        if (stage == 1) begin
            #1;
            model_ready = 1'b1;
            fpu_y = fmodel(fpu_ctl, fpu_x1, fpu_x2);
            stage = 2;
        end else if (stage == 2) begin
            #1;
            model_ready = 1'b0;
            stage = 0;
        end else if (fpu_en && fpu_ctl != 4'd7) begin
            stage = 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        ld_we = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
        shadow[a] = d;
    endtask

    // Compare the whole register file against the shadow copy, then realign to a negedge.
    task automatic sweep_rf(input string nm);
        for (int a = 0; a < 32; a++) begin
            rf_raddr = a[4:0];
            #1;
            chk(nm, rf_rdata, shadow[a]);
        end
        @(negedge clk);
    endtask

    // Issue one op from IDLE (at a negedge) and follow it to done or timeout.
    task automatic run_op(input vec_t v);
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] y;
        int n;
        sb_t e;
        chk1("idle_ready", dec_ready, 1'b1);
        dec_op = v.op;
        dec_rd = v.rd;
        dec_rs1 = v.rs1;
        dec_rs2 = v.rs2;
        dec_valid = 1'b1;
        x1 = shadow[v.rs1];
        x2 = shadow[v.rs2];
        y = fmodel(v.op, x1, x2);
        if (!v.to) sb_q.push_back('{v.rd, y});
        @(negedge clk);
        dec_valid = v.hold;
        chk1("en_pulse", fpu_en, 1'b1);
        chk1("busy_issue", dec_ready, 1'b0);
        chk("x1", fpu_x1, x1);
        chk("x2", fpu_x2, x2);
        chk("ctl", {28'd0, fpu_ctl}, {28'd0, v.op});
        n = 0;
        while (!(done || timeout_err) && n < 40) begin
            if (v.col && n == 2) begin
                ld_we = 1'b1;
                ld_addr = v.la;
                ld_data = v.ld;
            end else begin
                ld_we = 1'b0;
            end
            @(negedge clk);
            n++;
            if (!(done || timeout_err)) begin
                chk1("en_low", fpu_en, 1'b0);
                chk1("busy_wait", dec_ready, 1'b0);
                chk("x1_stable", fpu_x1, x1);
                chk("x2_stable", fpu_x2, x2);
                chk("ctl_stable", {28'd0, fpu_ctl}, {28'd0, v.op});
            end
        end
        ld_we = 1'b0;
        if (v.col) shadow[v.la] = v.ld;
        if (!v.to) begin
            chk1("done", done, 1'b1);
            chk1("no_to", timeout_err, 1'b0);
            chk("latency", 32'(n), 32'd3);
            chk1("ready_at_done", dec_ready, 1'b1);
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                e = sb_q.pop_front();
                shadow[e.rd] = e.y;
                rf_raddr = e.rd;
                #1;
                chk("wb", rf_rdata, e.y);
            end
            if (v.col) begin
                rf_raddr = v.la;
                #1;
                chk("ld_col", rf_rdata, shadow[v.la]);
            end
        end else begin
            chk1("to_pulse", timeout_err, 1'b1);
            chk1("to_no_done", done, 1'b0);
            chk("to_cycles", 32'(n), 32'(TIMEOUT + 1));
            chk1("to_idle", dec_ready, 1'b1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        spur_ready = 1'b0;
        rstn = 1'b0;
        dec_valid = 1'b0;
        dec_op = 4'd0;
        dec_rd = 5'd0;
        dec_rs1 = 5'd0;
        dec_rs2 = 5'd0;
        ld_we = 1'b0;
        ld_addr = 5'd0;
        ld_data = 32'd0;
        rf_raddr = 5'd0;
        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;

        //            op     rd     rs1    rs2   hold  to    col   la     ld
        vecs[0] = '{4'd2, 5'd3,  5'd1, 5'd2,  1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[1] = '{4'd2, 5'd4,  5'd3, 5'd1,  1'b1, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[2] = '{4'd5, 5'd6,  5'd4, 5'd4,  1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[3] = '{4'd3, 5'd0,  5'd6, 5'd3,  1'b1, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[4] = '{4'd1, 5'd31, 5'd0, 5'd31, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
        vecs[5] = '{4'd2, 5'd3,  5'd1, 5'd2,  1'b0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF};
        vecs[6] = '{4'd4, 5'd9,  5'd3, 5'd6,  1'b0, 1'b0, 1'b1, 5'd4, 32'h12345678};

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk1("rst_ready", dec_ready, 1'b1);
        chk1("rst_en", fpu_en, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_to", timeout_err, 1'b0);
        chk("rst_x1", fpu_x1, 32'd0);
        sweep_rf("rst_rf");

        load(5'd1, 32'h3F800000);
        load(5'd2, 32'h40000000);
        load(5'd31, 32'h00000055);

        for (int i = 0; i < 7; i++) run_op(vecs[i]);
        rf_raddr = 5'd3;
        #1;
        chk("rf3_col_final", rf_rdata, fmodel(4'd2, 32'h3F800000, 32'h40000000));
        @(negedge clk);

        // Unsupported op never answered: abort without touching the register file.
        run_op('{4'd7, 5'd8, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0});
        sweep_rf("to_rf");

        // Spurious ready while idle is ignored.
        spur_ready = 1'b1;
        @(negedge clk);
        spur_ready = 1'b0;
        chk1("spur_done", done, 1'b0);
        chk1("spur_ready", dec_ready, 1'b1);
        chk1("spur_en", fpu_en, 1'b0);
        @(negedge clk);
        chk1("spur_done2", done, 1'b0);
        sweep_rf("spur_rf");

        // Reset for one cycle during WAIT; the late FPU ready must be ignored.
        dec_op = 4'd2;
        dec_rd = 5'd5;
        dec_rs1 = 5'd1;
        dec_rs2 = 5'd2;
        dec_valid = 1'b1;
        @(negedge clk);
        dec_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk1("mrst_en", fpu_en, 1'b0);
        chk1("mrst_done", done, 1'b0);
        chk1("mrst_to", timeout_err, 1'b0);
        chk("mrst_ctl", {28'd0, fpu_ctl}, 32'd0);
        chk("mrst_x1", fpu_x1, 32'd0);
        chk("mrst_x2", fpu_x2, 32'd0);
        chk1("mrst_ready", dec_ready, 1'b1);
        @(negedge clk);
        chk1("mrst_late_done", done, 1'b0);
        @(negedge clk);
        chk1("mrst_late_done2", done, 1'b0);
        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
        sweep_rf("mrst_rf");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
- Issue/writeback sequencer directly upstream of the FPU wrapper.
- Owns the 32x32-bit FP register file and accepts decoded FP ops from the core decoder.
- Reads operands, pulses the FPU enable, holds the FPU inputs stable until the FPU's ready pulse, then writes the result back to the register file.
- Also provides a load write port and a debug/move read port, and aborts with an error if the FPU never answers.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before abort (2..255).
- CW, 8: width of the timeout counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- dec_valid  in  1  decoder presents an FP op.
- dec_ready  out  1  block can accept an op (high only in IDLE).
- dec_op  in  4  FPU ctl code (2 = fadd).
- dec_rd  in  5  destination FP register.
- dec_rs1  in  5  source FP register 1.
- dec_rs2  in  5  source FP register 2.
- ld_we  in  1  load writes FP register.
- ld_addr  in  5  load destination.
- ld_data  in  32  load data.
- rf_raddr  in  5  debug/move read address.
- rf_rdata  out  32  combinational read of the register file at rf_raddr.
- fpu_ctl  out  4  to FPU ctl.
- fpu_x1  out  32  to FPU x1.
- fpu_x2  out  32  to FPU x2.
- fpu_en  out  1  to FPU en, one-cycle pulse.
- fpu_ready  in  1  FPU result-valid pulse.
- fpu_y  in  32  FPU result.
- done  out  1  one-cycle pulse, writeback performed.
- timeout_err  out  1  one-cycle pulse, op aborted.

Behaviour:
- Reset, synchronous on rstn=0:
  - State goes to IDLE.
  - All 32 registers, fpu_ctl, fpu_x1, fpu_x2 and the timeout counter clear to 0.
  - fpu_en, done and timeout_err go to 0.
  - A reset mid-operation abandons the op with no writeback. A late fpu_ready after reset is ignored.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - dec_ready=1.
  - On dec_valid=1, capture the following into output registers: fpu_ctl<=dec_op, fpu_x1<=RF[dec_rs1], fpu_x2<=RF[dec_rs2], and the latched rd.
  - Go to ISSUE.
  - Operands come from register-file contents before this edge; a same-cycle ld_we to rs1/rs2 is not forwarded.
- ISSUE:
  - fpu_en=1 for exactly this cycle.
  - Go to WAIT and clear the counter.
- WAIT:
  - fpu_en=0.
  - fpu_ctl, fpu_x1 and fpu_x2 stay stable; the FPU samples ctl again when producing the result.
  - If fpu_ready=1: write RF[rd]<=fpu_y, done=1 next cycle, go to IDLE.
  - Else if counter==TIMEOUT-1: timeout_err=1 next cycle, no write, go to IDLE.
  - Else increment the counter.
- fpu_ready in IDLE or ISSUE is ignored.
- dec_ready is registered-state decoded (=state==IDLE). A new op can be accepted the cycle done is high.
- Latency with the current fadd FPU:
  - Accept edge E1, fpu_en high in the following cycle, FPU ready high after E3, writeback at E4.
  - done is high and dec_ready is high in the cycle after E4.
  - Throughput is one op per 4 cycles.
- Load port:
  - ld_we writes RF[ld_addr]<=ld_data in any state.
  - Same edge as FPU writeback, different address: both written.
  - Same address: FPU writeback wins.
- Unsupported dec_op (FPU never answers) resolves only via timeout.
- No register is hardwired to zero.

Test Plan:
- Basic fadd: load RF[1]=0x3F800000, RF[2]=0x40000000. Issue op=2, rd=3, rs1=1, rs2=2 with FPU model returning 0x40400000 three cycles after en.
  - Required: fpu_en high exactly one cycle.
  - Required: fpu_x1/fpu_x2/fpu_ctl stable through WAIT.
  - Required: RF[3]=0x40400000 and done pulse 4 cycles after accept; dec_ready low in between.
- Back-to-back: dec_valid held with two ops.
  - Required: second accepted the cycle done=1.
  - Required: the second op reads the first's rd correctly when rs1=previous rd.
- Timeout: op=7, FPU never asserts ready, TIMEOUT=16.
  - Required: timeout_err pulses after 16 WAIT cycles, no register changes, returns to IDLE.
- Write collision: ld_we to rd=3 with ld_data=0xDEADBEEF on the writeback edge.
  - Required: RF[3]=fpu_y.
  - Same edge with ld_addr=4: both registers written.
- Reset mid-WAIT: assert rstn=0 one cycle during WAIT, then the FPU model raises ready.
  - Required: all outputs 0, RF cleared, no writeback, no done.
- Spurious ready: fpu_ready pulse while IDLE.
  - Required: no state change, no write, done stays 0.
